mem_view_sequencer: RTL and testbench

Sequences the memory-inspection display: a free-running divider produces a single-cycle step tick at one of two selectable rates, and an FSM walks a word address through the instruction or data memory. Each addressed word is fetched over a one-cycle synchronous read port and presented, with its address, to the display path. Everything runs on the single system clock, with clock enables instead of derived clocks. It sits between the board controls (speed switch, memory select, run/step) and the seven-segment/LED display driver.

---
 rtl/mem_view_sequencer.sv | 161 ++++++++++++++++
 tb/tb_mem_view_sequencer.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_view_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : mem_view_sequencer
// Brief    : Steps a word address through imem/dmem on a divided tick or a
//            manual step, fetching each word for the display path.
// Revision : 1.0  initial release
// ============================================================================

module mem_view_sequencer #(
    parameter int FAST_BIT = 24,
    parameter int SLOW_BIT = 26,
    parameter int ADDR_W   = 5,
    parameter int DATA_W   = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              speed_sel,
    input  logic              mem_sel,
    input  logic              run,
    input  logic              step,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] imem_rdata,
    input  logic [DATA_W-1:0] dmem_rdata,
    output logic [ADDR_W-1:0] disp_addr,
    output logic [DATA_W-1:0] disp_data,
    output logic              disp_valid,
    output logic              wrap,
    output logic              busy
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ISSUE   = 2'd1,
        S_CAPTURE = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;

    logic [SLOW_BIT:0]   r_div_cnt;
    logic                r_fast_q;
    logic                r_slow_q;
    logic                r_step_q;
    logic                r_mem_sel_q;
    logic                r_fetch_sel;
    logic                r_adv_pend;
    logic                r_ref_pend;
    logic [ADDR_W-1:0]   r_cur_addr;
    logic [ADDR_W-1:0]   r_disp_addr;
    logic [DATA_W-1:0]   r_disp_data;
    logic                r_disp_valid;
    logic                r_wrap;

    logic                w_tick;
    logic                w_adv_evt;
    logic                w_ref_evt;
    logic                w_load_zero;
    logic                w_load_inc;
    logic                w_capture;
    logic                w_adv_pend_nxt;
    logic                w_ref_pend_nxt;

    // Both bit histories are kept live so a speed change never fakes an edge.
    assign w_tick    = speed_sel ? (r_div_cnt[FAST_BIT] & ~r_fast_q)
                                 : (r_div_cnt[SLOW_BIT] & ~r_slow_q);
    assign w_adv_evt = run ? w_tick : (step & ~r_step_q);
    assign w_ref_evt = mem_sel ^ r_mem_sel_q;

    always_comb begin
        w_state_nxt    = r_state;
        w_load_zero    = 1'b0;
        w_load_inc     = 1'b0;
        w_capture      = 1'b0;
        w_ref_pend_nxt = r_ref_pend | w_ref_evt;
        // A pending refresh supersedes any advance request.
        w_adv_pend_nxt = (r_ref_pend | w_ref_evt) ? 1'b0 : (r_adv_pend | w_adv_evt);
        case (r_state)
            S_IDLE: begin
                if (r_ref_pend || w_ref_evt) begin
                    w_load_zero    = 1'b1;
                    w_ref_pend_nxt = 1'b0;
                    w_adv_pend_nxt = 1'b0;
                    w_state_nxt    = S_ISSUE;
                end else if (r_adv_pend || w_adv_evt) begin
                    w_load_inc     = 1'b1;
                    w_adv_pend_nxt = 1'b0;
                    w_state_nxt    = S_ISSUE;
                end
            end
            S_ISSUE: begin
                w_state_nxt = S_CAPTURE;
            end
            S_CAPTURE: begin
                w_capture   = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_div_cnt    <= '0;
            r_fast_q     <= 1'b0;
            r_slow_q     <= 1'b0;
            r_step_q     <= 1'b0;
            r_mem_sel_q  <= mem_sel;
            r_fetch_sel  <= 1'b0;
            r_adv_pend   <= 1'b0;
            r_ref_pend   <= 1'b1;
            r_cur_addr   <= '0;
            r_disp_addr  <= '0;
            r_disp_data  <= '0;
            r_disp_valid <= 1'b0;
            r_wrap       <= 1'b0;
        end else begin
            r_div_cnt    <= r_div_cnt + 1'b1;
            r_fast_q     <= r_div_cnt[FAST_BIT];
            r_slow_q     <= r_div_cnt[SLOW_BIT];
            r_step_q     <= step;
            r_mem_sel_q  <= mem_sel;
            r_adv_pend   <= w_adv_pend_nxt;
            r_ref_pend   <= w_ref_pend_nxt;
            r_wrap       <= w_load_inc & (&r_cur_addr);
            r_disp_valid <= w_capture;
            if (w_load_zero) begin
                r_cur_addr <= '0;
            end else if (w_load_inc) begin
                r_cur_addr <= r_cur_addr + 1'b1;
            end
            // Freeze the memory choice while the address is on the port.
            if (r_state == S_ISSUE) begin
                r_fetch_sel <= r_mem_sel_q;
            end
            if (w_capture) begin
                r_disp_addr <= r_cur_addr;
                r_disp_data <= r_fetch_sel ? dmem_rdata : imem_rdata;
            end
        end
    end

    assign mem_addr   = r_cur_addr;
    assign disp_addr  = r_disp_addr;
    assign disp_data  = r_disp_data;
    assign disp_valid = r_disp_valid;
    assign wrap       = r_wrap;
    assign busy       = (r_state != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_mem_view_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_view_sequencer
// Brief    : Directed self-checking bench for mem_view_sequencer.
// Revision : 1.0  initial release
// ============================================================================

module tb_mem_view_sequencer;

    localparam int FAST_BIT = 2;
    localparam int SLOW_BIT = 4;
    localparam int ADDR_W   = 3;
    localparam int DATA_W   = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic              speed_sel;
    logic              mem_sel;
    logic              run;
    logic              step;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] imem_rdata = '0;
    logic [DATA_W-1:0] dmem_rdata = '0;
    logic [ADDR_W-1:0] disp_addr;
    logic [DATA_W-1:0] disp_data;
    logic              disp_valid;
    logic              wrap;
    logic              busy;

    int checks = 0;
    int errors = 0;

    mem_view_sequencer #(
        .FAST_BIT (FAST_BIT),
        .SLOW_BIT (SLOW_BIT),
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .speed_sel  (speed_sel),
        .mem_sel    (mem_sel),
        .run        (run),
        .step       (step),
        .mem_addr   (mem_addr),
        .imem_rdata (imem_rdata),
        .dmem_rdata (dmem_rdata),
        .disp_addr  (disp_addr),
        .disp_data  (disp_data),
        .disp_valid (disp_valid),
        .wrap       (wrap),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // One-cycle synchronous read memories: word i = 0x100+i / 0x200+i
    always @(posedge clk) begin
        imem_rdata <= 32'h100 + 32'(mem_addr);
        dmem_rdata <= 32'h200 + 32'(mem_addr);
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_valid(input int max_cyc, output bit found, output int cycles,
                              output int wraps);
        found  = 1'b0;
        cycles = 0;
        wraps  = 0;
        while (!found && cycles < max_cyc) begin
            cyc();
            cycles++;
            if (wrap === 1'b1) wraps++;
            if (disp_valid === 1'b1) found = 1'b1;
        end
    endtask

    bit found;
    int ncyc;
    int nwrap;

    initial begin
        rst = 1'b1; speed_sel = 1'b1; mem_sel = 1'b0; run = 1'b0; step = 1'b0;
        repeat (3) cyc();
        chk("rst_valid", 32'(disp_valid), 0);
        chk("rst_busy",  32'(busy), 0);
        chk("rst_wrap",  32'(wrap), 0);
        chk("rst_maddr", 32'(mem_addr), 0);
        chk("rst_daddr", 32'(disp_addr), 0);
        chk("rst_ddata", disp_data, 0);

        // Power-up refresh shows imem word 0 on the third clock
        rst = 1'b0;
        cyc();
        chk("pu_busy", 32'(busy), 1);
        wait_valid(10, found, ncyc, nwrap);
        chk("pu_found", 32'(found), 1);
        chk("pu_lat",   32'(ncyc + 1), 3);
        chk("pu_addr",  32'(disp_addr), 0);
        chk("pu_data",  disp_data, 32'h100);
        wait_valid(20, found, ncyc, nwrap);
        chk("idle_none", 32'(found), 0);

        // Fast auto-run: 8-clock spacing
        run = 1'b1;
        wait_valid(20, found, ncyc, nwrap);
        chk("f1_found", 32'(found), 1);
        chk("f1_addr",  32'(disp_addr), 1);
        chk("f1_data",  disp_data, 32'h101);
        wait_valid(20, found, ncyc, nwrap);
        chk("f2_gap",   32'(ncyc), 8);
        chk("f2_addr",  32'(disp_addr), 2);
        wait_valid(20, found, ncyc, nwrap);
        chk("f3_gap",   32'(ncyc), 8);
        chk("f3_addr",  32'(disp_addr), 3);

        // Slow: 32-clock spacing, no extra update at the switch
        speed_sel = 1'b0;
        wait_valid(40, found, ncyc, nwrap);
        chk("s4_found", 32'(found), 1);
        chk("s4_addr",  32'(disp_addr), 4);
        wait_valid(40, found, ncyc, nwrap);
        chk("s5_gap",   32'(ncyc), 32);
        chk("s5_addr",  32'(disp_addr), 5);

        // Back to fast through the rollover
        speed_sel = 1'b1;
        wait_valid(20, found, ncyc, nwrap);
        chk("f6_addr",  32'(disp_addr), 6);
        wait_valid(20, found, ncyc, nwrap);
        chk("f7_addr",  32'(disp_addr), 7);
        chk("f7_wrap",  32'(nwrap), 0);
        wait_valid(20, found, ncyc, nwrap);
        chk("w0_gap",   32'(ncyc), 8);
        chk("w0_wrap",  32'(nwrap), 1);
        chk("w0_addr",  32'(disp_addr), 0);
        chk("w0_data",  disp_data, 32'h100);

        // Manual mode: ticks ignored, held step gives one advance
        run = 1'b0;
        wait_valid(12, found, ncyc, nwrap);
        chk("man_idle", 32'(found), 0);
        step = 1'b1;
        wait_valid(6, found, ncyc, nwrap);
        chk("hold_lat",  32'(ncyc), 3);
        chk("hold_addr", 32'(disp_addr), 1);
        chk("hold_data", disp_data, 32'h101);
        wait_valid(17, found, ncyc, nwrap);
        chk("hold_once", 32'(found), 0);
        step = 1'b0;
        repeat (3) cyc();

        // Two step edges two clocks apart: second one is queued
        step = 1'b1; cyc();
        step = 1'b0; cyc();
        step = 1'b1; cyc();
        chk("dbl1_valid", 32'(disp_valid), 1);
        chk("dbl1_addr",  32'(disp_addr), 2);
        step = 1'b0;
        wait_valid(6, found, ncyc, nwrap);
        chk("dbl2_gap",  32'(ncyc), 3);
        chk("dbl2_addr", 32'(disp_addr), 3);
        chk("dbl2_data", disp_data, 32'h103);
        repeat (3) cyc();

        // mem_sel flips in CAPTURE together with a step edge
        step = 1'b1; cyc();
        step = 1'b0; cyc();
        chk("cap_busy", 32'(busy), 1);
        step = 1'b1; mem_sel = 1'b1; cyc();
        chk("cap_valid", 32'(disp_valid), 1);
        chk("cap_addr",  32'(disp_addr), 4);
        chk("cap_data",  disp_data, 32'h104);
        step = 1'b0;
        wait_valid(6, found, ncyc, nwrap);
        chk("ref_gap",  32'(ncyc), 3);
        chk("ref_addr", 32'(disp_addr), 0);
        chk("ref_data", disp_data, 32'h200);
        wait_valid(12, found, ncyc, nwrap);
        chk("ref_nostep", 32'(found), 0);

        // Reset while in ISSUE
        step = 1'b1; cyc();
        chk("iss_busy",  32'(busy), 1);
        chk("iss_maddr", 32'(mem_addr), 1);
        rst = 1'b1; step = 1'b0; cyc();
        chk("mr_busy",  32'(busy), 0);
        chk("mr_maddr", 32'(mem_addr), 0);
        chk("mr_daddr", 32'(disp_addr), 0);
        chk("mr_ddata", disp_data, 0);
        cyc();
        chk("mr_valid", 32'(disp_valid), 0);
        chk("mr_wrap",  32'(wrap), 0);
        rst = 1'b0;
        wait_valid(6, found, ncyc, nwrap);
        chk("rr_lat",  32'(ncyc), 3);
        chk("rr_addr", 32'(disp_addr), 0);
        chk("rr_data", disp_data, 32'h200);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
